prg_uploader: RTL

PRG_UPLOADER -- requirements
Module: prg_uploader

---
 rtl/prg_pkg.sv | 37 +++
 rtl/prg_rd_delay.sv | 32 +++
 rtl/prg_uploader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/prg_pkg.sv
// prg_pkg: shared constants and FSM state type for the PRG uploader and downloader.
//   TEXT_CPU    - CPU address where BASIC program text begins
//   VARTAB_PHYS - physical RAM address of the VARTAB pointer low byte (high byte at +1)
//   PHYS_OFS    - offset added to a CPU address to reach physical RAM
//   state_e     - uploader FSM states (ST_HDR only reachable with PRG_UPLOADER_HEADER_EN)
package prg_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 16;

  localparam logic [LEN_W-1:0]  TEXT_CPU    = 16'h8995;
  localparam logic [ADDR_W-1:0] VARTAB_PHYS = 25'h103E9;
  localparam logic [ADDR_W-1:0] PHYS_OFS    = 25'h8000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_WAIT_LO,
    ST_RD_HI,
    ST_WAIT_HI,
    ST_CHECK,
    ST_HDR,
    ST_RD_DATA,
    ST_WAIT_DATA,
    ST_SEND,
    ST_DONE,
    ST_ERR
  } state_e;

  // Map a 16-bit CPU address into the physical RAM space.
  function automatic logic [ADDR_W-1:0] cpu_to_phys(input logic [ADDR_W-1:0] ofs,
                                                     input logic [LEN_W-1:0]  cpu_addr);
    return ofs + ADDR_W'(cpu_addr);
  endfunction

endpackage

// File: rtl/prg_rd_delay.sv
// prg_rd_delay: RD_LAT-stage shift register turning the RAM read strobe into a
// "read data valid now" strobe aligned with the RAM's fixed read latency.
//   clk, reset_n - clock, synchronous active-low reset (clears in-flight reads)
//   rd_i         - read strobe as presented to the RAM
//   q_vld_o      - high exactly RD_LAT cycles after rd_i
module prg_rd_delay #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rd_i,
  output logic q_vld_o
);

  logic [RD_LAT-1:0] sr_q, sr_d;

  // Shift towards the MSB; the MSB marks read data arriving this cycle.
  always_comb begin
    sr_d = (sr_q << 1) | RD_LAT'(rd_i);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_vld_o = sr_q[RD_LAT-1];

endmodule

// File: rtl/prg_uploader.sv
// prg_uploader: reads VARTAB from RAM, derives the BASIC program length and
// streams the program bytes (TEXT_CPU .. VARTAB-1) to the io controller.
// Optional feature macro: PRG_UPLOADER_HEADER_EN prepends len[7:0], len[15:8].
//   clk, reset_n          - clock, synchronous active-low reset
//   start                 - upload request, honoured only when idle
//   busy, done, error     - status: active / success pulse / VARTAB < TEXT_CPU pulse
//   rd, addr, q           - RAM read port (q valid RD_LAT cycles after rd)
//   len                   - program length, held from the length check onward
//   out_valid/ready/data/last - valid/ready byte stream
module prg_uploader #(
  parameter logic [15:0] TEXT_CPU    = prg_pkg::TEXT_CPU,
  parameter logic [24:0] VARTAB_PHYS = prg_pkg::VARTAB_PHYS,
  parameter logic [24:0] PHYS_OFS    = prg_pkg::PHYS_OFS,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        rd,
  output logic [24:0] addr,
  input  logic [7:0]  q,
  output logic [15:0] len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  import prg_pkg::*;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    vartab_q, vartab_d;
  logic [LEN_W-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                rd_q, rd_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                q_vld;
`ifdef PRG_UPLOADER_HEADER_EN
  logic                hdr_hi_q, hdr_hi_d;
`endif

  prg_rd_delay #(.RD_LAT(RD_LAT)) u_rd_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_i    (rd_q),
    .q_vld_o (q_vld)
  );

  // Next state plus registered-output next values.
  always_comb begin
    state_d  = state_q;
    vartab_d = vartab_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    data_d   = data_q;
`ifdef PRG_UPLOADER_HEADER_EN
    hdr_hi_d = hdr_hi_q;
`endif

    case (state_q)
      ST_IDLE:    if (start) state_d = ST_RD_LO;
      ST_RD_LO:   state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (q_vld) begin
          vartab_d[7:0] = q;
          state_d       = ST_RD_HI;
        end
      end
      ST_RD_HI:   state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (q_vld) begin
          vartab_d[15:8] = q;
          state_d        = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (vartab_q < TEXT_CPU) begin
          state_d = ST_ERR;
        end else begin
          len_d = vartab_q - TEXT_CPU;
          ptr_d = TEXT_CPU;
          cnt_d = len_d;
`ifdef PRG_UPLOADER_HEADER_EN
          data_d   = len_d[7:0];
          hdr_hi_d = 1'b0;
          state_d  = ST_HDR;
`else
          state_d = (len_d == '0) ? ST_DONE : ST_RD_DATA;
`endif
        end
      end
`ifdef PRG_UPLOADER_HEADER_EN
      ST_HDR: begin
        if (out_ready) begin
          if (!hdr_hi_q) begin
            hdr_hi_d = 1'b1;
            data_d   = len_q[15:8];
          end else begin
            state_d = (cnt_q == '0) ? ST_DONE : ST_RD_DATA;
          end
        end
      end
`endif
      ST_RD_DATA: state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (q_vld) begin
          data_d  = q;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          ptr_d   = ptr_q + 16'd1;
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_d != '0) ? ST_RD_DATA : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERR);
    rd_d    = (state_d == ST_RD_LO) || (state_d == ST_RD_HI) || (state_d == ST_RD_DATA);

    addr_d = addr_q;
    if (state_d == ST_RD_LO) begin
      addr_d = VARTAB_PHYS;
    end else if (state_d == ST_RD_HI) begin
      addr_d = VARTAB_PHYS + 25'd1;
    end else if (state_d == ST_RD_DATA) begin
      addr_d = cpu_to_phys(PHYS_OFS, ptr_d);
    end

    valid_d = (state_d == ST_SEND);
    last_d  = valid_d && (cnt_d == 16'd1);
`ifdef PRG_UPLOADER_HEADER_EN
    if (state_d == ST_HDR) begin
      valid_d = 1'b1;
      last_d  = hdr_hi_d && (cnt_d == '0);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      vartab_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rd_q     <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PRG_UPLOADER_HEADER_EN
      hdr_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vartab_q <= vartab_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef PRG_UPLOADER_HEADER_EN
      hdr_hi_q <= hdr_hi_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign rd        = rd_q;
  assign addr      = addr_q;
  assign len       = len_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule
